// File: rtl/counter_gen.sv
// counter_gen: address/value sequence generator.
// After an accepted run and an optional idle delay, it walks an address
// through `iterations` periods of `period` cycles. The first min(duty, period)
// cycles of each period are valid and step the address by `incr`. Each period
// end also adds `shift` to the address. All configuration is captured when run
// is accepted, so the inputs may change freely while a sequence is in flight.
module counter_gen #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              done,
    input  logic [ADDR_W-1:0] start,
    input  logic [ADDR_W-1:0] incr,
    input  logic [ADDR_W-1:0] shift,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  duty,
    input  logic [CNT_W-1:0]  iterations,
    input  logic [CNT_W-1:0]  delay,
    output logic [ADDR_W-1:0] out0,
    output logic              valid
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        GEN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] incr_q, incr_d;
    logic [ADDR_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] out0_q, out0_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W-1:0]  it_q, it_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  eff_duty_q, eff_duty_d;
    logic [CNT_W-1:0]  iter_q, iter_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;

    logic              in_duty;
    logic [ADDR_W-1:0] addr_step;

    // Next-state, counter and output computation for the IDLE/DELAY/GEN sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        incr_d     = incr_q;
        shift_d    = shift_q;
        out0_d     = out0_q;
        valid_d    = 1'b0;
        per_d      = per_q;
        it_d       = it_q;
        period_d   = period_q;
        eff_duty_d = eff_duty_q;
        iter_d     = iter_q;
        dcnt_d     = dcnt_q;
        in_duty    = (per_q < eff_duty_q);
        addr_step  = in_duty ? (addr_q + incr_q) : addr_q;

        case (state_q)
            IDLE: begin
                // An empty sequence (zero period or zero iterations) never leaves IDLE.
                if (run && (period != '0) && (iterations != '0)) begin
                    addr_d     = start;
                    incr_d     = incr;
                    shift_d    = shift;
                    period_d   = period;
                    eff_duty_d = (duty > period) ? period : duty;
                    iter_d     = iterations;
                    dcnt_d     = delay;
                    per_d      = '0;
                    it_d       = '0;
                    state_d    = (delay != '0) ? DELAY : GEN;
                end
            end
            DELAY: begin
                if (dcnt_q <= CNT_ONE) begin
                    dcnt_d  = '0;
                    state_d = GEN;
                end else begin
                    dcnt_d = dcnt_q - CNT_ONE;
                end
            end
            GEN: begin
                out0_d  = addr_q;
                valid_d = in_duty;
                addr_d  = addr_step;
                if (per_q == period_q - CNT_ONE) begin
                    per_d  = '0;
                    addr_d = addr_step + shift_q;
                    it_d   = it_q + CNT_ONE;
                    if (it_q == iter_q - CNT_ONE) begin
                        state_d = IDLE;
                    end
                end else begin
                    per_d = per_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            incr_q     <= '0;
            shift_q    <= '0;
            out0_q     <= '0;
            valid_q    <= 1'b0;
            per_q      <= '0;
            it_q       <= '0;
            period_q   <= '0;
            eff_duty_q <= '0;
            iter_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            incr_q     <= incr_d;
            shift_q    <= shift_d;
            out0_q     <= out0_d;
            valid_q    <= valid_d;
            per_q      <= per_d;
            it_q       <= it_d;
            period_q   <= period_d;
            eff_duty_q <= eff_duty_d;
            iter_q     <= iter_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign done  = (state_q == IDLE);
    assign out0  = out0_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_counter_gen.sv
// Directed testbench for counter_gen: each task drives one scenario and
// checks hand-computed sample values one cycle at a time (#1 after posedge).
module tb_counter_gen;

    logic       clk;
    logic       rst;
    logic       run;
    logic       done;
    logic [9:0] start;
    logic [9:0] incr;
    logic [9:0] shift;
    logic [9:0] period;
    logic [9:0] duty;
    logic [9:0] iterations;
    logic [9:0] delay;
    logic [9:0] out0;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    counter_gen #(.ADDR_W(10), .CNT_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .done       (done),
        .start      (start),
        .incr       (incr),
        .shift      (shift),
        .period     (period),
        .duty       (duty),
        .iterations (iterations),
        .delay      (delay),
        .out0       (out0),
        .valid      (valid)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_cfg(input logic [9:0] s, input logic [9:0] i, input logic [9:0] sh,
                           input logic [9:0] p, input logic [9:0] du, input logic [9:0] it,
                           input logic [9:0] dl);
        start = s; incr = i; shift = sh; period = p; duty = du; iterations = it; delay = dl;
    endtask

    // Called 1 ns after a posedge; run is sampled at the next edge (edge T).
    task automatic fire_run();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        set_cfg(10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
        #2;
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || out0 !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset: done=%b valid=%b out0=%0d required done=1 valid=0 out0=0",
                     done, valid, out0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_cfg(10'd5, 10'd1, 10'd0, 10'd4, 10'd4, 10'd2, 10'd0);
        fire_run();
        for (int k = 1; k <= 10; k++) begin
            logic       ev;
            logic [9:0] eo;
            @(posedge clk);
            #1;
            ev = (k <= 8);
            eo = (k <= 8) ? 10'(5 + k - 1) : 10'd12;
            checks++;
            if (valid !== ev || out0 !== eo) begin
                failures++;
                $display("[TB] FAIL basic k=%0d: valid=%b out0=%0d required valid=%b out0=%0d",
                         k, valid, out0, ev, eo);
            end
            if (k != 8) begin
                checks++;
                if (done !== (k >= 9)) begin
                    failures++;
                    $display("[TB] FAIL basic_done k=%0d: done=%b required %b", k, done, (k >= 9));
                end
            end
        end
    endtask

    task automatic test_delay_pattern();
        int         j = 0;
        logic [9:0] exp_out [6] = '{10'd0, 10'd2, 10'd20, 10'd22, 10'd40, 10'd42};
        set_cfg(10'd0, 10'd2, 10'd16, 10'd4, 10'd2, 10'd3, 10'd3);
        fire_run();
        for (int k = 1; k <= 16; k++) begin
            logic ev;
            @(posedge clk);
            #1;
            ev = (k >= 4 && k <= 15) ? (((k - 4) % 4) < 2) : 1'b0;
            checks++;
            if (valid !== ev) begin
                failures++;
                $display("[TB] FAIL delay_valid k=%0d: valid=%b required %b", k, valid, ev);
            end
            if (ev) begin
                checks++;
                if (out0 !== exp_out[j]) begin
                    failures++;
                    $display("[TB] FAIL delay_out k=%0d: out0=%0d required %0d", k, out0, exp_out[j]);
                end
                j++;
            end
            if (k <= 14 || k == 16) begin
                checks++;
                if (done !== (k == 16)) begin
                    failures++;
                    $display("[TB] FAIL delay_done k=%0d: done=%b required %b", k, done, (k == 16));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_out [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        set_cfg(10'd1022, 10'd1, 10'd0, 10'd4, 10'd4, 10'd1, 10'd0);
        fire_run();
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k <= 4 && (valid !== 1'b1 || out0 !== exp_out[k-1])) begin
                failures++;
                $display("[TB] FAIL wrap k=%0d: valid=%b out0=%0d required valid=1 out0=%0d",
                         k, valid, out0, exp_out[k-1]);
            end else if (k == 5 && (valid !== 1'b0 || done !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL wrap_end: valid=%b done=%b required valid=0 done=1", valid, done);
            end
        end
    endtask

    task automatic test_zero_cfg();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) set_cfg(10'd3, 10'd1, 10'd0, 10'd0, 10'd2, 10'd2, 10'd0);
            else        set_cfg(10'd3, 10'd1, 10'd0, 10'd4, 10'd2, 10'd0, 10'd0);
            fire_run();
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk);
                #1;
                checks++;
                if (done !== 1'b1 || valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL zero_cfg c=%0d k=%0d: done=%b valid=%b required done=1 valid=0",
                             c, k, done, valid);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        set_cfg(10'd5, 10'd1, 10'd0, 10'd4, 10'd4, 10'd2, 10'd0);
        fire_run();
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            run = 1'b0;
            checks++;
            if (k <= 8 && (valid !== 1'b1 || out0 !== 10'(5 + k - 1))) begin
                failures++;
                $display("[TB] FAIL rerun k=%0d: valid=%b out0=%0d required valid=1 out0=%0d",
                         k, valid, out0, 5 + k - 1);
            end else if (k == 9 && (valid !== 1'b0 || done !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL rerun_end: valid=%b done=%b required valid=0 done=1", valid, done);
            end
            if (k == 3) begin
                run = 1'b1;
                set_cfg(10'd100, 10'd7, 10'd3, 10'd2, 10'd1, 10'd5, 10'd2);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(10'd5, 10'd1, 10'd0, 10'd4, 10'd4, 10'd2, 10'd0);
        fire_run();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
        end
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0 || out0 !== 10'd0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid: valid=%b out0=%0d done=%b required valid=0 out0=0 done=1",
                     valid, out0, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fire_run();
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k <= 8 && (valid !== 1'b1 || out0 !== 10'(5 + k - 1))) begin
                failures++;
                $display("[TB] FAIL after_reset k=%0d: valid=%b out0=%0d required valid=1 out0=%0d",
                         k, valid, out0, 5 + k - 1);
            end else if (k == 9 && done !== 1'b1) begin
                failures++;
                $display("[TB] FAIL after_reset_done: done=%b required 1", done);
            end
        end
    endtask

    task automatic test_duty_clamp();
        set_cfg(10'd0, 10'd1, 10'd0, 10'd4, 10'd6, 10'd1, 10'd0);
        fire_run();
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k <= 4 && (valid !== 1'b1 || out0 !== 10'(k - 1))) begin
                failures++;
                $display("[TB] FAIL clamp k=%0d: valid=%b out0=%0d required valid=1 out0=%0d",
                         k, valid, out0, k - 1);
            end else if (k > 4 && (valid !== 1'b0 || done !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL clamp_end k=%0d: valid=%b done=%b required valid=0 done=1",
                         k, valid, done);
            end
        end
    endtask

    task automatic test_duty_zero();
        set_cfg(10'd0, 10'd1, 10'd0, 10'd3, 10'd0, 10'd2, 10'd0);
        fire_run();
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (valid !== 1'b0 || (k <= 5 && done !== 1'b0) || (k == 7 && done !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL duty_zero k=%0d: valid=%b done=%b required valid=0 done=%b",
                         k, valid, done, (k == 7));
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_basic();
        test_delay_pattern();
        test_wrap();
        test_zero_cfg();
        test_back_to_back();
        test_reset_mid();
        test_duty_clamp();
        test_duty_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
